// File: rtl/seq_alu_if.sv
// Request/response bundle for seq_alu: operands and op select in, registered result and flags out.
interface seq_alu_if #(
  parameter int WIDTH = 16
);
  logic [WIDTH-1:0] a_i;
  logic [WIDTH-1:0] b_i;
  logic [5:0]       fun_sel_i;
  logic             wf_i;
  logic             in_valid_i;
  logic             in_ready_o;
  logic             out_valid_o;
  logic [WIDTH-1:0] alu_out_o;
  logic [WIDTH-1:0] alu_out_hi_o;
  logic [3:0]       flags_out_o;

  modport master (
    output a_i, b_i, fun_sel_i, wf_i, in_valid_i,
    input  in_ready_o, out_valid_o, alu_out_o, alu_out_hi_o, flags_out_o
  );

  modport slave (
    input  a_i, b_i, fun_sel_i, wf_i, in_valid_i,
    output in_ready_o, out_valid_o, alu_out_o, alu_out_hi_o, flags_out_o
  );
endinterface

// File: rtl/seq_alu.sv
// Registered full/half-width ALU with valid/ready request port and {Z,C,N,O} flag register.
// Define ALU_MUL_EN to build the iterative shift-add unsigned multiplier (FunSel[5]).
module seq_alu #(
  parameter int WIDTH = 16
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  seq_alu_if.slave   bus
);
  localparam int H = WIDTH / 2;

  logic [WIDTH-1:0]       alu_out_q, alu_out_d;
  logic [WIDTH-1:0]       alu_out_hi_q, alu_out_hi_d;
  logic [3:0]             flags_q, flags_d;
  logic                   out_valid_q, out_valid_d;
  logic                   in_ready;
  logic                   accept;
  logic                   is_mul;

  logic [1:0][WIDTH-1:0]  core_res;
  logic [1:0]             core_c;
  logic [1:0]             core_o;
  logic [WIDTH-1:0]       op_res;
  logic                   op_c, op_o, op_n, op_z;

  assign is_mul = bus.fun_sel_i[5];
  assign accept = bus.in_valid_i & in_ready;

  // Core 0 handles the half-width view, core 1 the full width; flags come from each core's own MSB.
  for (genvar gi = 0; gi < 2; gi++) begin : g_core
    localparam int NW = (gi == 1) ? WIDTH : H;
    logic [NW-1:0] a_w, b_w, res_w;
    logic [NW:0]   sum_w;
    logic          cin_w, c_w, o_w;

    assign a_w   = bus.a_i[NW-1:0];
    assign b_w   = bus.b_i[NW-1:0];
    assign cin_w = flags_q[2];

    always_comb begin
      sum_w = '0;
      res_w = '0;
      c_w   = flags_q[2];
      o_w   = flags_q[0];
      case (bus.fun_sel_i[3:0])
        4'd0:  res_w = a_w;
        4'd1:  res_w = b_w;
        4'd2:  res_w = ~a_w;
        4'd3:  res_w = ~b_w;
        4'd4, 4'd5: begin
          sum_w = {1'b0, a_w} + {1'b0, b_w}
                + {{NW{1'b0}}, (bus.fun_sel_i[3:0] == 4'd5) & cin_w};
          res_w = sum_w[NW-1:0];
          c_w   = sum_w[NW];
          o_w   = (a_w[NW-1] == b_w[NW-1]) && (res_w[NW-1] != a_w[NW-1]);
        end
        4'd6: begin
          sum_w = {1'b0, a_w} + {1'b0, ~b_w} + {{NW{1'b0}}, 1'b1};
          res_w = sum_w[NW-1:0];
          c_w   = ~sum_w[NW];  // no carry out means A < B
          o_w   = (a_w[NW-1] != b_w[NW-1]) && (res_w[NW-1] != a_w[NW-1]);
        end
        4'd7:  res_w = a_w & b_w;
        4'd8:  res_w = a_w | b_w;
        4'd9:  res_w = a_w ^ b_w;
        4'd10: res_w = ~(a_w & b_w);
        4'd11: begin res_w = {a_w[NW-2:0], 1'b0};      c_w = a_w[NW-1]; end
        4'd12: begin res_w = {1'b0, a_w[NW-1:1]};      c_w = a_w[0];    end
        4'd13: begin res_w = {a_w[NW-1], a_w[NW-1:1]}; c_w = a_w[0];    end
        4'd14: begin res_w = {a_w[NW-2:0], cin_w};     c_w = a_w[NW-1]; end
        4'd15: begin res_w = {cin_w, a_w[NW-1:1]};     c_w = a_w[0];    end
        default: res_w = '0;
      endcase
    end

    assign core_res[gi] = WIDTH'(res_w);
    assign core_c[gi]   = c_w;
    assign core_o[gi]   = o_w;
  end

  always_comb begin
    op_res = bus.fun_sel_i[4] ? core_res[1] : core_res[0];
    op_c   = bus.fun_sel_i[4] ? core_c[1]   : core_c[0];
    op_o   = bus.fun_sel_i[4] ? core_o[1]   : core_o[0];
    op_n   = bus.fun_sel_i[4] ? op_res[WIDTH-1] : op_res[H-1];
  end

  assign op_z = (op_res == '0);

`ifdef ALU_MUL_EN
  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic {S_IDLE, S_MUL} state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   prod_q, prod_d;
  logic [WIDTH-1:0]     mcand_q, mcand_d;
  logic                 wf_q, wf_d;
  logic                 mul_done;
  logic [WIDTH:0]       mul_sum;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept && is_mul) state_d = S_MUL;
      S_MUL:   if (cnt_q == CW'(WIDTH)) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state_q == S_IDLE);
    mul_done = (state_q == S_MUL) && (cnt_q == CW'(WIDTH));
  end

  // Product register holds {partial high, remaining multiplier bits}; one add-and-shift per cycle.
  always_comb begin
    mcand_d = mcand_q;
    prod_d  = prod_q;
    cnt_d   = cnt_q;
    wf_d    = wf_q;
    mul_sum = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
    if (accept && is_mul) begin
      mcand_d = bus.a_i;
      prod_d  = {{WIDTH{1'b0}}, bus.b_i};
      cnt_d   = '0;
      wf_d    = bus.wf_i;
    end else if ((state_q == S_MUL) && !mul_done) begin
      prod_d  = {mul_sum, prod_q[WIDTH-1:1]};
      cnt_d   = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mcand_q <= '0;
      prod_q  <= '0;
      cnt_q   <= '0;
      wf_q    <= 1'b0;
    end else begin
      mcand_q <= mcand_d;
      prod_q  <= prod_d;
      cnt_q   <= cnt_d;
      wf_q    <= wf_d;
    end
  end
`else
  assign in_ready = 1'b1;
`endif

  always_comb begin
    alu_out_d    = alu_out_q;
    alu_out_hi_d = alu_out_hi_q;
    flags_d      = flags_q;
    out_valid_d  = 1'b0;
    if (accept && !is_mul) begin
      alu_out_d    = op_res;
      alu_out_hi_d = '0;
      out_valid_d  = 1'b1;
      if (bus.wf_i) flags_d = {op_z, op_c, op_n, op_o};
    end
`ifdef ALU_MUL_EN
    if (mul_done) begin
      alu_out_d    = prod_q[WIDTH-1:0];
      alu_out_hi_d = prod_q[2*WIDTH-1:WIDTH];
      out_valid_d  = 1'b1;
      if (wf_q) flags_d = {prod_q == '0, |prod_q[2*WIDTH-1:WIDTH], 1'b0, |prod_q[2*WIDTH-1:WIDTH]};
    end
`else
    if (accept && is_mul) begin
      alu_out_d    = '0;
      alu_out_hi_d = '0;
      out_valid_d  = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      alu_out_q    <= '0;
      alu_out_hi_q <= '0;
      flags_q      <= '0;
      out_valid_q  <= 1'b0;
    end else begin
      alu_out_q    <= alu_out_d;
      alu_out_hi_q <= alu_out_hi_d;
      flags_q      <= flags_d;
      out_valid_q  <= out_valid_d;
    end
  end

  assign bus.in_ready_o   = in_ready;
  assign bus.out_valid_o  = out_valid_q;
  assign bus.alu_out_o    = alu_out_q;
  assign bus.alu_out_hi_o = alu_out_hi_q;
  assign bus.flags_out_o  = flags_q;

endmodule

// File: tb/tb_seq_alu.sv
// Randomized self-checking bench for seq_alu against an arithmetic reference model.
// Builds for both configurations; the multiplier checks are enabled by ALU_MUL_EN.
module tb_seq_alu;
  localparam int W = 16;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  seq_alu_if #(.WIDTH(W)) bus ();
  seq_alu #(.WIDTH(W)) dut (.clk_i(clk), .rst_ni(rst_n), .bus(bus));

  int checks   = 0;
  int failures = 0;
  int txn      = 0;
  logic [W-1:0] exp_out, exp_hi;
  logic [3:0]   exp_flags;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference model: plain integer arithmetic on the active width.
  task automatic model_req(input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [5:0] fs, input logic wf);
    longint av, bv, mask, top, sa, sb, sr, r;
    int nw;
    logic cin, c, o;
    if (fs[5]) begin
`ifdef ALU_MUL_EN
      longint p;
      p = longint'(a) * longint'(b);
      exp_out = W'(p);
      exp_hi  = W'(p >> W);
      if (wf) exp_flags = {p == 0, exp_hi != 0, 1'b0, exp_hi != 0};
`else
      exp_out = '0;
      exp_hi  = '0;
`endif
      return;
    end
    nw   = fs[4] ? W : W / 2;
    mask = (longint'(1) << nw) - 1;
    top  = longint'(1) << (nw - 1);
    av   = longint'(a) & mask;
    bv   = longint'(b) & mask;
    sa   = (av >= top) ? av - 2 * top : av;
    sb   = (bv >= top) ? bv - 2 * top : bv;
    cin  = exp_flags[2];
    c    = cin;
    o    = exp_flags[0];
    r    = 0;
    case (fs[3:0])
      4'd0:  r = av;
      4'd1:  r = bv;
      4'd2:  r = ~av;
      4'd3:  r = ~bv;
      4'd4:  begin r = av + bv; c = r > mask; sr = sa + sb; o = (sr < -top) || (sr >= top); end
      4'd5:  begin r = av + bv + longint'(cin); c = r > mask;
                   sr = sa + sb + longint'(cin); o = (sr < -top) || (sr >= top); end
      4'd6:  begin r = av - bv; c = av < bv; sr = sa - sb; o = (sr < -top) || (sr >= top); end
      4'd7:  r = av & bv;
      4'd8:  r = av | bv;
      4'd9:  r = av ^ bv;
      4'd10: r = ~(av & bv);
      4'd11: begin r = av << 1; c = av >= top; end
      4'd12: begin r = av >> 1; c = (av & 1) != 0; end
      4'd13: begin r = sa >>> 1; c = (av & 1) != 0; end
      4'd14: begin r = (av << 1) | longint'(cin); c = av >= top; end
      4'd15: begin r = (av >> 1) | (cin ? top : 0); c = (av & 1) != 0; end
      default: r = 0;
    endcase
    r = r & mask;
    exp_out = W'(r);
    exp_hi  = '0;
    if (wf) exp_flags = {r == 0, c, r >= top, o};
  endtask

  // Single-cycle request; entered and left at a falling edge.
  task automatic step_req(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [5:0] fs, input logic wf);
    bus.a_i = a; bus.b_i = b; bus.fun_sel_i = fs; bus.wf_i = wf; bus.in_valid_i = 1'b1;
    check("in_ready", bus.in_ready_o, 1);
    model_req(a, b, fs, wf);
    @(posedge clk); #1;
    check("out_valid", bus.out_valid_o, 1);
    check("alu_out", bus.alu_out_o, exp_out);
    check("alu_out_hi", bus.alu_out_hi_o, exp_hi);
    check("flags", bus.flags_out_o, exp_flags);
    txn++;
    $display("txn %0d op fs=%b a=%h b=%h wf=%0d -> out=%h hi=%h flags=%b",
             txn, fs, a, b, wf, bus.alu_out_o, bus.alu_out_hi_o, bus.flags_out_o);
    @(negedge clk);
  endtask

`ifdef ALU_MUL_EN
  // Multi-cycle request; junk requests are thrown at the block while it is busy.
  task automatic mul_req(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [5:0] fs, input logic wf);
    int busy;
    logic early;
    bus.a_i = a; bus.b_i = b; bus.fun_sel_i = fs; bus.wf_i = wf; bus.in_valid_i = 1'b1;
    check("mul_in_ready", bus.in_ready_o, 1);
    model_req(a, b, fs, wf);
    @(posedge clk);
    busy  = 0;
    early = 1'b0;
    for (int k = 0; k < 4 * W; k++) begin
      @(negedge clk);
      if (bus.in_ready_o) break;
      busy++;
      if (bus.out_valid_o) early = 1'b1;
      bus.in_valid_i = 1'($urandom_range(0, 1));
      bus.a_i        = W'($urandom);
      bus.b_i        = W'($urandom);
      bus.fun_sel_i  = 6'($urandom);
      bus.wf_i       = 1'($urandom_range(0, 1));
    end
    bus.in_valid_i = 1'b0;
    check("mul_busy_cycles", busy, W + 1);
    check("mul_early_valid", early, 0);
    check("mul_out_valid", bus.out_valid_o, 1);
    check("mul_lo", bus.alu_out_o, exp_out);
    check("mul_hi", bus.alu_out_hi_o, exp_hi);
    check("mul_flags", bus.flags_out_o, exp_flags);
    txn++;
    $display("txn %0d mul a=%h b=%h wf=%0d -> hi=%h lo=%h flags=%b busy=%0d",
             txn, a, b, wf, bus.alu_out_hi_o, bus.alu_out_o, bus.flags_out_o, busy);
  endtask
`endif

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [W-1:0] ra, rb;
    logic [5:0]   rfs;
    logic         rwf;
    logic         stray;

    bus.in_valid_i = 1'b0; bus.a_i = '0; bus.b_i = '0; bus.fun_sel_i = '0; bus.wf_i = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_out", bus.alu_out_o, 0);
    check("rst_hi", bus.alu_out_hi_o, 0);
    check("rst_flags", bus.flags_out_o, 0);
    check("rst_valid", bus.out_valid_o, 0);
    rst_n = 1'b1;
    exp_out = '0; exp_hi = '0; exp_flags = '0;
    @(negedge clk);

    // Directed cases
    step_req(16'h7FFF, 16'h0001, 6'b010100, 1'b1);
    check("add_ovf_out", bus.alu_out_o, 16'h8000);
    check("add_ovf_flags", bus.flags_out_o, 4'b0011);
    bus.in_valid_i = 1'b0;
    @(posedge clk); #1;
    check("valid_one_pulse", bus.out_valid_o, 0);
    check("out_holds", bus.alu_out_o, 16'h8000);
    @(negedge clk);

    step_req(16'hAB05, 16'h1207, 6'b000110, 1'b1);
    check("half_sub_out", bus.alu_out_o, 16'h00FE);
    check("half_sub_flags", bus.flags_out_o, 4'b0110);

    step_req(16'hFFFF, 16'h0001, 6'b010100, 1'b1);
    check("add_zero_flags", bus.flags_out_o, 4'b1100);
    step_req(16'h4000, 16'h0000, 6'b011110, 1'b1);
    check("rol_c_out", bus.alu_out_o, 16'h8001);
    check("rol_c_flags", bus.flags_out_o, 4'b0010);

`ifdef ALU_MUL_EN
    mul_req(16'h1234, 16'h0100, 6'b100000, 1'b1);
    check("mul_dir_hi", bus.alu_out_hi_o, 16'h0012);
    check("mul_dir_lo", bus.alu_out_o, 16'h3400);
    check("mul_dir_flags", bus.flags_out_o, 4'b0101);
`else
    step_req(16'h1234, 16'h0100, 6'b100000, 1'b1);
    check("nomul_out", bus.alu_out_o, 16'h0000);
    check("nomul_hi", bus.alu_out_hi_o, 16'h0000);
    check("nomul_flags", bus.flags_out_o, 4'b0010);
`endif

    // Reset in the middle of an operation
    bus.a_i = 16'hBEEF; bus.b_i = 16'h0003; bus.wf_i = 1'b1; bus.in_valid_i = 1'b1;
`ifdef ALU_MUL_EN
    bus.fun_sel_i = 6'b100000;
`else
    bus.fun_sel_i = 6'b010100;
`endif
    @(posedge clk);
    @(negedge clk);
    bus.in_valid_i = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_out", bus.alu_out_o, 0);
    check("abort_hi", bus.alu_out_hi_o, 0);
    check("abort_flags", bus.flags_out_o, 0);
    check("abort_valid", bus.out_valid_o, 0);
    @(negedge clk);
    rst_n = 1'b1;
    exp_out = '0; exp_hi = '0; exp_flags = '0;
    stray = 1'b0;
    for (int k = 0; k < W + 4; k++) begin
      @(negedge clk);
      if (bus.out_valid_o) stray = 1'b1;
    end
    check("abort_no_stray_valid", stray, 0);
    check("abort_ready", bus.in_ready_o, 1);

    // Randomized traffic, mostly back-to-back
    for (int i = 0; i < 300; i++) begin
      ra  = W'($urandom);
      rb  = W'($urandom);
      rfs = 6'($urandom);
      rwf = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 7))
        0: ra = 16'h0000;
        1: ra = 16'hFFFF;
        2: begin ra = 16'h7FFF; rb = 16'h8000; end
        3: rb = ra;
        default: ;
      endcase
      if ($urandom_range(0, 7) == 0) begin
        bus.in_valid_i = 1'b0;
        @(posedge clk); #1;
        check("idle_no_valid", bus.out_valid_o, 0);
        @(negedge clk);
      end
`ifdef ALU_MUL_EN
      if (rfs[5]) mul_req(ra, rb, rfs, rwf);
      else        step_req(ra, rb, rfs, rwf);
`else
      step_req(ra, rb, rfs, rwf);
`endif
    end
    bus.in_valid_i = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/seq_alu.md
# seq_alu

Parametrised, registered successor to the datapath ALU with a valid/ready request interface. It executes full-width or half-width operations in one cycle, and an optional iterative unsigned multiply. Results and Z/C/N/O flags are held in output registers. It sits between the register file/operand muxes and the write-back path, and the control unit drives it through a request handshake.

## Interface
- WIDTH, 16: datapath width; even, ≥ 4. Half-width H = WIDTH/2.
- Clock  in  1  rising-edge clock.
- Reset  in  1  asynchronous, active-low reset.
- A  in  WIDTH  operand A.
- B  in  WIDTH  operand B.
- FunSel  in  6  operation select:
  - [5] = MUL.
  - [4] = 1 full width, 0 half width.
  - [3:0] = op code.
- WF  in  1  write flags for this request.
- InValid  in  1  request present.
- InReady  out  1  block can accept a request this cycle.
- OutValid  out  1  one-cycle pulse: ALUOut/ALUOutHi/FlagsOut updated.
- ALUOut  out  WIDTH  result (low half of product for MUL).
- ALUOutHi  out  WIDTH  high half of product; 0 for non-MUL ops.
- FlagsOut  out  4  {Z, C, N, O} at bits [3:0].

## Operation
- Acceptance: a request is accepted on a rising edge with InValid & InReady. A, B, FunSel, WF and the current FlagsOut[2] (carry-in) are sampled at that edge.
- FSM states: IDLE and MUL.
  - IDLE: InReady = 1.
  - Accepted non-MUL request: stays in IDLE. Result is registered at the acceptance edge.
  - Accepted MUL request: goes to MUL. InReady = 0 while in MUL.
  - MUL: shift-add over WIDTH iterations, one per cycle, with a counter of $clog2(WIDTH)+1 bits. Returns to IDLE on the edge that writes the product.
- Width rule (FunSel[4] = 0):
  - Operands are A[H-1:0] and B[H-1:0].
  - Result is zero-extended into ALUOut.
  - Flags come from bit H-1 and the carry out of bit H-1.
- Op codes [3:0], with n = active width:
  - 0: A. 1: B. 2: ~A. 3: ~B.
  - 4: ADD. 5: ADC (adds carry-in). 6: SUB = A + ~B + 1.
  - 7: AND. 8: OR. 9: XOR. 10: NAND.
  - 11: LSL. 12: LSR. 13: ASR.
  - 14: rotate left through C, {A[n-2:0], Cin}.
  - 15: rotate right through C, {Cin, A[n-1:1]}.
- Flags, written only when the sampled WF = 1; otherwise FlagsOut holds:
  - Z = (result == 0). N = result[n-1].
  - Ops 4/5: C = carry out; O = signed overflow (operand signs equal, result sign differs).
  - Op 6: C = borrow (A < B unsigned); O = signed overflow of subtraction.
  - Ops 11 and 14: C = A[n-1]. Ops 12, 13, 15: C = A[0].
  - All other ops: C and O unchanged.
- MUL:
  - Unsigned WIDTH×WIDTH product, {ALUOutHi, ALUOut}. FunSel[4:0] is ignored.
  - Flags: Z = (product == 0), N = 0, C = O = (ALUOutHi != 0).
- Reset (asserted, including mid-MUL):
  - Aborts any operation; state goes to IDLE.
  - ALUOut = 0, ALUOutHi = 0, FlagsOut = 4'b0000, OutValid = 0, InReady = 1 after release.
  - No OutValid is issued for an aborted request.
- InValid while InReady = 0 is ignored (not queued). The requester holds it until accepted.

## Timing
- Non-MUL latency: 1 cycle. Outputs and OutValid change at the acceptance edge; OutValid is high for the following cycle.
- Back-to-back non-MUL requests are accepted every cycle; OutValid stays high continuously.
- MUL latency: WIDTH+1 edges from acceptance to the product/OutValid edge. InReady is low for WIDTH+1 cycles after acceptance.
- A new request is accepted in the first IDLE cycle, which is the same cycle OutValid is high.
- ADC or rotate issued immediately after a flag-writing op sees the updated C (flags are registered before the next acceptance edge).
- ALUOut and ALUOutHi hold their value between OutValid pulses.

## Configuration
- ALU_MUL_EN defined: MUL path, MUL state and counter are compiled in as above.
- ALU_MUL_EN undefined:
  - FunSel[5] = 1 is accepted as a 1-cycle op: ALUOut = ALUOutHi = 0, OutValid pulses, FlagsOut unchanged regardless of WF.
  - InReady is constantly 1 outside reset.

## Test plan
- WIDTH=16, ADD full, A=16'h7FFF, B=16'h0001, WF=1 -> next cycle ALUOut=16'h8000, FlagsOut=4'b0011, OutValid one pulse.
- Half-width SUB, A=16'hAB05, B=16'h1207, WF=1 -> ALUOut=16'h00FE, Z=0, C=1, N=1, O=0.
- ADD with WF=1, A=16'hFFFF, B=16'h0001 -> Z=1, C=1. Next cycle op 14 on A=16'h4000 -> ALUOut=16'h8001, C=0.
- MUL (ALU_MUL_EN), A=16'h1234, B=16'h0100 -> after 17 edges ALUOutHi=16'h0012, ALUOut=16'h3400, C=O=1. InReady low 17 cycles; InValid pulses during that window are ignored.
- Reset asserted at cycle 5 of a MUL -> immediately all outputs 0, FlagsOut=0. After release, InReady=1 and no stray OutValid.
- ALU_MUL_EN undefined, FunSel=6'b100000, WF=1 with prior flags 4'b1010 -> ALUOut=0, ALUOutHi=0, FlagsOut stays 4'b1010, OutValid pulses after 1 cycle.
